id_hazard_ctrl: RTL and testbench

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

---
 rtl/id_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_id_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: register scoreboard, RAW/WAW stall generation,
// branch-flush override and halt/drain sequencing with a saturating stall counter.
module id_hazard_ctrl #(
  parameter bit WB_BYPASS   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1_addr,
  input  logic [4:0]             id_rs2_addr,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [4:0]             id_dest_addr,
  input  logic                   id_halt,
  input  logic                   ex_flush,
  input  logic                   wb_reg_write_en,
  input  logic [4:0]             wb_reg_write_addr,
  output logic                   id_issue,
  output logic                   id_stall,
  output logic                   id_bubble,
  output logic                   if_stall,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [31:0]            pending,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_pending;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_halted;

  logic [31:0] w_wb_clr;
  logic [31:0] w_busy;
  logic [31:0] w_set;
  logic [31:0] w_pending_nxt;
  logic        w_hazard;
  logic        w_run;
  logic        w_issue;
  logic        w_stall;

  // Per-register writeback clear, busy (optionally bypassed by same-cycle WB) and issue set.
  always_comb begin
    w_wb_clr = '0;
    w_busy   = '0;
    w_set    = '0;
    for (int n = 1; n < 32; n++) begin
      w_wb_clr[n] = wb_reg_write_en && (wb_reg_write_addr == n[4:0]);
      w_busy[n]   = r_pending[n] && !(WB_BYPASS && w_wb_clr[n]);
      w_set[n]    = w_issue && (id_dest_addr == n[4:0]);
    end
  end

  assign w_hazard = id_valid &&
                    ((id_rs1_used && w_busy[id_rs1_addr]) ||
                     (id_rs2_used && w_busy[id_rs2_addr]) ||
                     w_busy[id_dest_addr]);

  assign w_run = (r_state == S_RUN) || (r_state == S_STALL);

  // A flush kills the ID instruction outright, so it never stalls or issues.
  always_comb begin
    w_issue = 1'b0;
    w_stall = 1'b1;
    if (w_run) begin
      w_issue = id_valid && !w_hazard && !ex_flush;
      w_stall = w_hazard && !ex_flush;
    end
  end

  // Set wins over clear when an issue and a writeback target the same register.
  assign w_pending_nxt = w_set | (r_pending & ~w_wb_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_RUN, S_STALL: begin
          if (w_issue && id_halt) begin
            r_state <= S_DRAIN;
          end else if (w_stall) begin
            r_state <= S_STALL;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (ex_flush) begin
            r_state <= S_RUN;
          end else if (w_pending_nxt == 32'd0) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_HALTED;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_run && w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign id_issue    = w_issue;
  assign id_stall    = w_stall;
  assign id_bubble   = !w_issue;
  assign if_stall    = w_stall;
  assign halted      = r_halted;
  assign state       = r_state;
  assign pending     = r_pending;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expectations are queued when stimulus is
// applied and popped against DUT outputs half a cycle later.
module tb_id_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1_addr, id_rs2_addr, id_dest_addr, wb_reg_write_addr;
  logic          id_rs1_used, id_rs2_used, id_halt, ex_flush, wb_reg_write_en;
  logic          id_issue, id_stall, id_bubble, if_stall, halted;
  logic [1:0]    state;
  logic [31:0]   pending;
  logic [CW-1:0] stall_count;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  id_hazard_ctrl #(.WB_BYPASS(1'b1), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_dest_addr(id_dest_addr),
    .id_halt(id_halt), .ex_flush(ex_flush),
    .wb_reg_write_en(wb_reg_write_en), .wb_reg_write_addr(wb_reg_write_addr),
    .id_issue(id_issue), .id_stall(id_stall), .id_bubble(id_bubble), .if_stall(if_stall),
    .halted(halted), .state(state), .pending(pending), .stall_count(stall_count)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] d,
                     input logic h, input logic f, input logic we, input logic [4:0] wa);
    id_valid = v; id_rs1_addr = r1; id_rs1_used = u1; id_rs2_addr = r2; id_rs2_used = u2;
    id_dest_addr = d; id_halt = h; ex_flush = f; wb_reg_write_en = we; wb_reg_write_addr = wa;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard
  task automatic exp(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %0h, no expectation queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    exp(0); exp(0); exp(0); exp(0); exp(0); exp(1);
    chk("rst_state", state); chk("rst_pending", pending); chk("rst_count", stall_count);
    chk("rst_halted", halted); chk("rst_issue", id_issue); chk("rst_bubble", id_bubble);
    rst = 1'b1;

    // Issue dest=x5, then consumer stalls, then WB bypass releases it
    @(negedge clk);
    drv(1, 1, 1, 0, 0, 5, 0, 0, 0, 0);
    exp(1); exp(0); exp(32'h20);
    #1 chk("a_issue", id_issue); chk("a_stall", id_stall);
    @(negedge clk);
    chk("a_pend5", pending);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    exp(1); exp(1); exp(0); exp(1); exp(1); exp(1);
    #1 chk("raw_stall", id_stall); chk("raw_bubble", id_bubble);
    chk("raw_issue", id_issue); chk("raw_if_stall", if_stall);
    @(negedge clk);
    chk("raw_state", state); chk("raw_count", stall_count);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 1, 5);
    exp(1); exp(0); exp(0); exp(0); exp(1);
    #1 chk("byp_issue", id_issue); chk("byp_stall", id_stall);
    @(negedge clk);
    chk("byp_pending", pending); chk("byp_state", state); chk("byp_count", stall_count);

    // x0 never tracked
    drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    exp(1); exp(0);
    #1 chk("x0_issue", id_issue);
    @(negedge clk);
    chk("x0_pending", pending);

    // Set wins over clear on x7
    drv(1, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    exp(32'h80);
    @(negedge clk);
    chk("x7_pend", pending);
    drv(1, 0, 0, 0, 0, 7, 0, 0, 1, 7);
    exp(1); exp(32'h80);
    #1 chk("waw_byp_issue", id_issue);
    @(negedge clk);
    chk("set_wins", pending);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    exp(0);
    @(negedge clk);
    chk("x7_clr", pending);

    // WB to a non-pending register is ignored
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
    exp(0);
    @(negedge clk);
    chk("stray_wb", pending);

    // Flush overrides a hazard on x3
    drv(1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    @(negedge clk);
    drv(1, 0, 0, 3, 1, 0, 0, 1, 0, 0);
    exp(0); exp(0); exp(1); exp(0); exp(0); exp(1); exp(32'h8);
    #1 chk("fl_stall", id_stall); chk("fl_issue", id_issue);
    chk("fl_bubble", id_bubble); chk("fl_if_stall", if_stall);
    @(negedge clk);
    chk("fl_state", state); chk("fl_count", stall_count); chk("fl_pending", pending);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    @(negedge clk);

    // Halt with x9 pending drains, then halts on WB x9
    drv(1, 0, 0, 0, 0, 9, 0, 0, 0, 0);
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    exp(1); exp(2);
    #1 chk("halt_issue", id_issue);
    @(negedge clk);
    chk("drain_state", state);
    drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    exp(1); exp(0); exp(1); exp(2);
    #1 chk("drain_if_stall", if_stall); chk("drain_issue", id_issue); chk("drain_id_stall", id_stall);
    @(negedge clk);
    chk("drain_hold", state);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    exp(3); exp(1);
    @(negedge clk);
    chk("halted_state", state); chk("halted_out", halted);
    idle();
    exp(3); exp(1); exp(1);
    @(negedge clk);
    chk("halted_sticky", state); chk("halted_sticky_out", halted); chk("halted_count", stall_count);
    #2 rst = 1'b0;
    exp(0); exp(0);
    #1 chk("rst_async_state", state); chk("rst_async_halted", halted);
    @(negedge clk);
    rst = 1'b1;

    // Flush during drain returns to RUN
    drv(1, 0, 0, 0, 0, 9, 0, 0, 0, 0);
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    exp(0); exp(32'h200);
    @(negedge clk);
    chk("drain_flush_state", state); chk("drain_flush_pend", pending);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    @(negedge clk);

    // Halt with nothing pending: DRAIN for one cycle, then HALTED
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    exp(2);
    @(negedge clk);
    chk("empty_drain", state);
    idle();
    exp(3); exp(1);
    @(negedge clk);
    chk("empty_halted", state); chk("empty_halted_out", halted);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Stall-count saturation, then asynchronous reset mid-stall
    drv(1, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    @(negedge clk);
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat ((1 << CW) + 3) @(negedge clk);
    exp({CW{1'b1}}); exp(1); exp(32'h10);
    chk("sat_count", stall_count); chk("sat_state", state); chk("sat_pending", pending);
    #2 rst = 1'b0;
    exp(0); exp(0); exp(0); exp(0); exp(0); exp(1); exp(0);
    #1 chk("mid_rst_count", stall_count); chk("mid_rst_pending", pending);
    chk("mid_rst_state", state); chk("mid_rst_halted", halted);
    chk("mid_rst_stall", id_stall); chk("mid_rst_issue", id_issue); chk("mid_rst_if_stall", if_stall);
    @(negedge clk);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    exp(0);
    @(negedge clk);
    chk("late_wb", pending);

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: %0d expectations never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
